// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, state encoding and requester IDs
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with update-on-grant pointer
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_q;
  logic ptr_d;

  // Lone requester wins; on contention the pointed side wins. en_i gates everything.
  always_comb begin
    gnt_a_o = en_i && req_a_i && (!req_b_i || (ptr_q == REQ_A));
    gnt_b_o = en_i && req_b_i && (!req_a_i || (ptr_q == REQ_B));
    ptr_d   = ptr_q;
    if (gnt_a_o) begin
      ptr_d = REQ_B;
    end else if (gnt_b_o) begin
      ptr_d = REQ_A;
    end
  end

  // Pointer register; favours A after reset and only moves when a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - zero sweep sequencer and two-port arbiter for the 8x32 register file
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              serve_en;

  // Grants exist only in SERVE and are squashed while reset is asserted.
  assign serve_en = (state_q == ST_SERVE) && !reset;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (serve_en),
    .req_a_i (a_req),
    .req_b_i (b_req),
    .gnt_a_o (a_gnt),
    .gnt_b_o (b_gnt)
  );

  // Next state and file-port muxing: sweep zeros in INIT, route the granted requester in SERVE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_raddr    = '0;
    case (state_q)
      ST_INIT: begin
        rf_we    = !reset;
        rf_waddr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_SERVE;
          init_done_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (a_gnt) begin
          rf_we = a_we;
          if (a_we) begin
            rf_waddr = a_addr;
            rf_wdata = a_wdata;
          end else begin
            rf_raddr = a_addr;
          end
        end else if (b_gnt) begin
          rf_we = b_we;
          if (b_we) begin
            rf_waddr = b_addr;
            rf_wdata = b_wdata;
          end else begin
            rf_raddr = b_addr;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read return: a read grant captures the file output; data holds between reads.
  always_comb begin
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
    a_rdata_d  = a_rvalid_d ? rf_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? rf_rdata : b_rdata_q;
  end

  // State, sweep counter and read-return registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter with register file model
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr, rf_raddr;
  logic [31:0] rf_wdata, rf_rdata;
  logic        init_done;

  always #5 clk = ~clk;

  // Register file the block fronts: one write port, combinational read.
  logic [31:0] rf_mem [8] = '{default: 32'hA5A5A5A5};
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .init_done(init_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ref_mem [8];
  bit          ref_serving;
  int          ref_cnt;
  int          ref_ptr;      // 1 = A favoured, 2 = B favoured
  bit          exp_av, exp_bv;
  logic [31:0] exp_ad, exp_bd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs();
    chk("a_rvalid", 32'(a_rvalid), 32'(exp_av));
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_bv));
    chk("a_rdata", a_rdata, exp_ad);
    chk("b_rdata", b_rdata, exp_bd);
    chk("init_done", 32'(init_done), 32'(ref_serving));
  endtask

  task automatic do_reset(input bit ar, input bit aw, input logic [2:0] aa, input logic [31:0] ad);
    reset = 1'b1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 32'd0;
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    tick();
    ref_serving = 1'b0; ref_cnt = 0; ref_ptr = 1;
    exp_av = 1'b0; exp_bv = 1'b0; exp_ad = 32'd0; exp_bd = 32'd0;
    check_regs();
  endtask

  // g: 0 = no grant, 1 = A, 2 = B
  task automatic do_cycle(input bit ar, input bit aw, input logic [2:0] aa, input logic [31:0] ad,
                          input bit br, input bit bw, input logic [2:0] ba, input logic [31:0] bd,
                          output int g);
    bit          we;
    logic [2:0]  addr;
    logic [31:0] data;
    reset = 1'b0;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    g = 0;
    we = 1'b0; addr = 3'd0; data = 32'd0;
    if (!ref_serving) begin
      chk("init_a_gnt", 32'(a_gnt), 32'd0);
      chk("init_b_gnt", 32'(b_gnt), 32'd0);
      chk("init_rf_we", 32'(rf_we), 32'd1);
      chk("init_waddr", 32'(rf_waddr), 32'(ref_cnt));
      chk("init_wdata", rf_wdata, 32'd0);
    end else begin
      if (ar && (!br || ref_ptr == 1)) g = 1;
      else if (br) g = 2;
      chk("a_gnt", 32'(a_gnt), 32'(g == 1));
      chk("b_gnt", 32'(b_gnt), 32'(g == 2));
      if (g == 0) begin
        chk("idle_rf_we", 32'(rf_we), 32'd0);
        chk("idle_raddr", 32'(rf_raddr), 32'd0);
        chk("idle_waddr", 32'(rf_waddr), 32'd0);
        chk("idle_wdata", rf_wdata, 32'd0);
      end else begin
        we   = (g == 1) ? aw : bw;
        addr = (g == 1) ? aa : ba;
        data = (g == 1) ? ad : bd;
        chk("rf_we", 32'(rf_we), 32'(we));
        if (we) begin
          chk("rf_waddr", 32'(rf_waddr), 32'(addr));
          chk("rf_wdata", rf_wdata, data);
        end else begin
          chk("rf_raddr", 32'(rf_raddr), 32'(addr));
        end
      end
    end
    tick();
    exp_av = 1'b0; exp_bv = 1'b0;
    if (!ref_serving) begin
      ref_mem[ref_cnt] = 32'd0;
      if (ref_cnt == 7) begin
        ref_serving = 1'b1;
        ref_cnt = 0;
      end else begin
        ref_cnt++;
      end
    end else if (g != 0) begin
      if (we) ref_mem[addr] = data;
      else if (g == 1) begin exp_av = 1'b1; exp_ad = ref_mem[addr]; end
      else begin exp_bv = 1'b1; exp_bd = ref_mem[addr]; end
      ref_ptr = (g == 1) ? 2 : 1;
    end
    check_regs();
  endtask

  initial begin
    int          g;
    bit          pa, paw, pb, pbw;
    logic [2:0]  paa, pba;
    logic [31:0] pad, pbd;

    // Reset with A already requesting a read
    do_reset(1'b1, 1'b0, 3'd3, 32'd0);
    do_reset(1'b1, 1'b0, 3'd3, 32'd0);

    // Zero sweep: eight cycles, request held but never granted
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
      chk("sweep_no_gnt", 32'(g), 32'd0);
    end
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
    chk("first_gnt_A", 32'(g), 32'd1);
    chk("swept_rdata", a_rdata, 32'd0);

    // Write/readback
    do_cycle(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 1'b0, 3'd0, 32'd0, g);
    do_cycle(1'b1, 1'b0, 3'd5, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
    chk("wr_rb_valid", 32'(a_rvalid), 32'd1);
    chk("wr_rb_data", a_rdata, 32'hDEADBEEF);

    // Streaming: A fills reg k with k*3, B reads all back-to-back
    for (int k = 0; k < 8; k++)
      do_cycle(1'b1, 1'b1, 3'(k), 32'(k * 3), 1'b0, 1'b0, 3'd0, 32'd0, g);
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'(k), 32'd0, g);
      chk("stream_bvalid", 32'(b_rvalid), 32'd1);
      chk("stream_bdata", b_rdata, 32'(k * 3));
      chk("stream_avalid", 32'(a_rvalid), 32'd0);
    end

    // Fairness: last grant was B, so contention alternates starting with A
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b0, 3'd2, 32'd0, 1'b1, 1'b0, 3'd6, 32'd0, g);
      chk("fair_order", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Idle leaves the pointer on A
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
    do_cycle(1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 1'b0, 3'd7, 32'd0, g);
    chk("idle_ptr", 32'(g), 32'd1);
    do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd7, 32'd0, g);
    chk("idle_then_b", 32'(g), 32'd2);

    // Reset in the cycle an A read would be granted
    do_reset(1'b1, 1'b0, 3'd4, 32'd0);
    chk("midrst_rvalid", 32'(a_rvalid), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    for (int k = 0; k < 8; k++)
      do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
    do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, g);
    chk("resweep_rdata", a_rdata, 32'd0);

    // Randomized traffic; requests hold their payload until granted
    pa = 1'b0; pb = 1'b0;
    paw = 1'b0; pbw = 1'b0; paa = 3'd0; pba = 3'd0; pad = 32'd0; pbd = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; paw = 1'($urandom_range(0, 1)); paa = 3'($urandom_range(0, 7)); pad = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; pbw = 1'($urandom_range(0, 1)); pba = 3'($urandom_range(0, 7)); pbd = $urandom;
      end
      if (c == 200) begin
        do_reset(pa, paw, paa, pad);
      end else begin
        do_cycle(pa, paw, paa, pad, pb, pbw, pba, pbd, g);
        if (g == 1) pa = 1'b0;
        if (g == 2) pb = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
